// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared constants for the pipeline control sequencer:
//                PC source select encodings, sequencer state encodings and a
//                helper that maps a trap/mret request to its PC source.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    // PC source select
    localparam logic [1:0] PC_SEL_PC4    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_TRAP   = 2'b10;
    localparam logic [1:0] PC_SEL_MEPC   = 2'b11;

    // Sequencer states
    localparam logic [1:0] PC_RUN       = 2'b00;
    localparam logic [1:0] PC_MD_WAIT   = 2'b01;
    localparam logic [1:0] PC_DRAIN     = 2'b10;
    localparam logic [1:0] PC_TRAP_HOLD = 2'b11;

    // A trap takes precedence over mret, so only a lone mret selects mepc.
    function automatic logic [1:0] redirect_sel(input logic is_mret);
        return is_mret ? PC_SEL_MEPC : PC_SEL_TRAP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Hazard/request inputs and stall/flush/redirect outputs
//                exchanged between the pipeline datapath and pipe_ctrl.
//                master : datapath side (drives requests, receives controls)
//                slave  : pipe_ctrl side (receives requests, drives controls)
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int REG_AW = 5
);
    // Requests / hazard sources
    logic              take_branch;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_rd;
    logic              id_rs2_rd;
    logic              ex_mem_read;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_muldiv_start;
    logic              muldiv_done;
    logic              lsu_wait;
    logic              lsu_pending;
    logic              trap_req;
    logic              mret_req;

    // Pipeline controls
    logic              if_stall;
    logic              id_stall;
    logic              ex_stall;
    logic              mem_stall;
    logic              if_flush;
    logic              id_flush;
    logic              ex_flush;
    logic              mem_flush;
    logic              wb_flush;
    logic [1:0]        pc_sel;
    logic              trap_ack;

    modport master (
        output take_branch, id_rs1, id_rs2, id_rs1_rd, id_rs2_rd,
               ex_mem_read, ex_rd, ex_muldiv_start, muldiv_done,
               lsu_wait, lsu_pending, trap_req, mret_req,
        input  if_stall, id_stall, ex_stall, mem_stall,
               if_flush, id_flush, ex_flush, mem_flush, wb_flush,
               pc_sel, trap_ack
    );

    modport slave (
        input  take_branch, id_rs1, id_rs2, id_rs1_rd, id_rs2_rd,
               ex_mem_read, ex_rd, ex_muldiv_start, muldiv_done,
               lsu_wait, lsu_pending, trap_req, mret_req,
        output if_stall, id_stall, ex_stall, mem_stall,
               if_flush, id_flush, ex_flush, mem_flush, wb_flush,
               pc_sel, trap_ack
    );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_lu_hazard_det.sv
`default_nettype none
// ============================================================================
//  Module      : lu_hazard_det
//  Description : Combinational load-use hazard compare. Flags when the
//                instruction in EX is a load whose destination (non-x0) is a
//                source actually read by the instruction in ID.
//  Ports       : i_mem_read  EX holds a load
//                i_rd        EX destination register
//                i_rs1/i_rs2 ID source registers
//                i_rs1_rd/i_rs2_rd  ID reads rs1/rs2
//                o_hazard    load-use hazard present
//  Revision    : 1.0  initial release
// ============================================================================
module lu_hazard_det #(
    parameter int REG_AW = 5
) (
    input  wire logic              i_mem_read,
    input  wire logic [REG_AW-1:0] i_rd,
    input  wire logic [REG_AW-1:0] i_rs1,
    input  wire logic [REG_AW-1:0] i_rs2,
    input  wire logic              i_rs1_rd,
    input  wire logic              i_rs2_rd,
    output logic                   o_hazard
);

    logic w_rd_nz;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is hardwired to zero, so a load into it never creates a dependency.
    assign w_rd_nz   = (i_rd != '0);
    assign w_rs1_hit = i_rs1_rd && (i_rs1 == i_rd);
    assign w_rs2_hit = i_rs2_rd && (i_rs2 == i_rd);
    assign o_hazard  = i_mem_read && w_rd_nz && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Stall/flush/redirect sequencer for the 5-stage core.
//                Arbitrates traps/mret, taken branches, MUL/DIV waits, LSU
//                waits and load-use hazards; drives per-stage stall/flush and
//                the PC source select; keeps stall and redirect counters.
//  Ports       : clk        core clock
//                rst_n      asynchronous active-low reset
//                bus        pipe_ctrl_if slave (requests in, controls out)
//                stall_cnt  cycles with if_stall asserted (wrapping)
//                redir_cnt  cycles with pc_sel != PC+4 (wrapping)
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int PERF_W = 32,
    parameter int REG_AW = 5
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    pipe_ctrl_if.slave    bus,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] redir_cnt
);

    logic [1:0]        r_state;
    logic              r_lat_mret;
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_redir_cnt;

    logic [1:0] w_next_state;
    logic       w_latch_en;
    logic       w_hazard;
    logic       w_req;
    logic       w_if_stall, w_id_stall, w_ex_stall, w_mem_stall;
    logic       w_if_flush, w_id_flush, w_ex_flush, w_mem_flush, w_wb_flush;
    logic [1:0] w_pc_sel;
    logic       w_trap_ack;

    lu_hazard_det #(
        .REG_AW (REG_AW)
    ) u_lu_hazard_det (
        .i_mem_read (bus.ex_mem_read),
        .i_rd       (bus.ex_rd),
        .i_rs1      (bus.id_rs1),
        .i_rs2      (bus.id_rs2),
        .i_rs1_rd   (bus.id_rs1_rd),
        .i_rs2_rd   (bus.id_rs2_rd),
        .o_hazard   (w_hazard)
    );

    assign w_req = bus.trap_req || bus.mret_req;

    always_comb begin
        w_next_state = r_state;
        w_latch_en   = 1'b0;
        w_if_stall   = 1'b0;
        w_id_stall   = 1'b0;
        w_ex_stall   = 1'b0;
        w_mem_stall  = 1'b0;
        w_if_flush   = 1'b0;
        w_id_flush   = 1'b0;
        w_ex_flush   = 1'b0;
        w_mem_flush  = 1'b0;
        w_wb_flush   = 1'b0;
        w_pc_sel     = PC_SEL_PC4;
        w_trap_ack   = 1'b0;

        case (r_state)
            PC_RUN: begin
                if (w_req && !bus.lsu_pending) begin
                    w_pc_sel     = redirect_sel(!bus.trap_req);
                    w_if_flush   = 1'b1;
                    w_id_flush   = 1'b1;
                    w_ex_flush   = 1'b1;
                    w_mem_flush  = 1'b1;
                    w_trap_ack   = 1'b1;
                    w_next_state = PC_TRAP_HOLD;
                end else if (w_req) begin
                    // Outstanding store must retire before redirecting;
                    // freeze everything and keep WB from re-committing.
                    w_if_stall   = 1'b1;
                    w_id_stall   = 1'b1;
                    w_ex_stall   = 1'b1;
                    w_mem_stall  = 1'b1;
                    w_wb_flush   = 1'b1;
                    w_latch_en   = 1'b1;
                    w_next_state = PC_DRAIN;
                end else if (bus.take_branch) begin
                    // Also covers a concurrent load-use: the dependent ID
                    // instruction is on the wrong path and gets flushed.
                    w_pc_sel   = PC_SEL_BRANCH;
                    w_if_flush = 1'b1;
                    w_id_flush = 1'b1;
                end else if (bus.lsu_wait) begin
                    w_if_stall  = 1'b1;
                    w_id_stall  = 1'b1;
                    w_ex_stall  = 1'b1;
                    w_mem_stall = 1'b1;
                    w_wb_flush  = 1'b1;
                end else if (bus.ex_muldiv_start) begin
                    if (!bus.muldiv_done) begin
                        w_if_stall   = 1'b1;
                        w_id_stall   = 1'b1;
                        w_ex_stall   = 1'b1;
                        w_mem_flush  = 1'b1;
                        w_next_state = PC_MD_WAIT;
                    end
                end else if (w_hazard) begin
                    // One bubble into EX; next cycle the load has moved on
                    // and the compare naturally clears.
                    w_if_stall = 1'b1;
                    w_id_stall = 1'b1;
                    w_ex_flush = 1'b1;
                end
            end

            PC_MD_WAIT: begin
                if (bus.muldiv_done) begin
                    w_next_state = PC_RUN;
                end else begin
                    w_if_stall  = 1'b1;
                    w_id_stall  = 1'b1;
                    w_ex_stall  = 1'b1;
                    w_mem_flush = 1'b1;
                end
            end

            PC_DRAIN: begin
                if (bus.lsu_pending) begin
                    w_if_stall  = 1'b1;
                    w_id_stall  = 1'b1;
                    w_ex_stall  = 1'b1;
                    w_mem_stall = 1'b1;
                    w_wb_flush  = 1'b1;
                end else begin
                    w_pc_sel     = redirect_sel(r_lat_mret);
                    w_if_flush   = 1'b1;
                    w_id_flush   = 1'b1;
                    w_ex_flush   = 1'b1;
                    w_mem_flush  = 1'b1;
                    w_trap_ack   = 1'b1;
                    w_next_state = PC_TRAP_HOLD;
                end
            end

            // The trapping instruction may still be visible at MEM for one
            // cycle; ignoring requests here prevents a second trap.
            PC_TRAP_HOLD: begin
                w_next_state = PC_RUN;
            end

            default: begin
                w_next_state = PC_RUN;
            end
        endcase
    end

    // Outputs forced quiet while reset is held.
    assign bus.if_stall  = rst_n && w_if_stall;
    assign bus.id_stall  = rst_n && w_id_stall;
    assign bus.ex_stall  = rst_n && w_ex_stall;
    assign bus.mem_stall = rst_n && w_mem_stall;
    assign bus.if_flush  = rst_n && w_if_flush;
    assign bus.id_flush  = rst_n && w_id_flush;
    assign bus.ex_flush  = rst_n && w_ex_flush;
    assign bus.mem_flush = rst_n && w_mem_flush;
    assign bus.wb_flush  = rst_n && w_wb_flush;
    assign bus.pc_sel    = rst_n ? w_pc_sel : PC_SEL_PC4;
    assign bus.trap_ack  = rst_n && w_trap_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PC_RUN;
            r_lat_mret  <= 1'b0;
            r_stall_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_latch_en) begin
                r_lat_mret <= !bus.trap_req;
            end
            r_stall_cnt <= r_stall_cnt + PERF_W'(w_if_stall);
            r_redir_cnt <= r_redir_cnt + PERF_W'(w_pc_sel != PC_SEL_PC4);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign redir_cnt = r_redir_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed self-checking bench for pipe_ctrl.
//                Control vector layout (12 bits):
//                [11] if_stall [10] id_stall [9] ex_stall [8] mem_stall
//                [7] if_flush [6] id_flush [5] ex_flush [4] mem_flush
//                [3] wb_flush [2:1] pc_sel [0] trap_ack
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int PERF_W = 32;
    localparam int REG_AW = 5;

    localparam logic [11:0] C_NONE = 12'b0000_0000_0000;
    localparam logic [11:0] C_LU   = 12'b1100_0010_0000;
    localparam logic [11:0] C_BR   = 12'b0000_1100_0010;
    localparam logic [11:0] C_MD   = 12'b1110_0001_0000;
    localparam logic [11:0] C_HOLD = 12'b1111_0000_1000;
    localparam logic [11:0] C_TRAP = 12'b0000_1111_0101;
    localparam logic [11:0] C_MRET = 12'b0000_1111_0111;

    logic              clk;
    logic              rst_n;
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] redir_cnt;
    logic [11:0]       w_ctl;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_ctrl_if #(.REG_AW(REG_AW)) bus ();

    pipe_ctrl #(
        .PERF_W (PERF_W),
        .REG_AW (REG_AW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .stall_cnt (stall_cnt),
        .redir_cnt (redir_cnt)
    );

    assign w_ctl = {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall,
                    bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush,
                    bus.wb_flush, bus.pc_sel, bus.trap_ack};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.take_branch     = 1'b0;
        bus.id_rs1          = '0;
        bus.id_rs2          = '0;
        bus.id_rs1_rd       = 1'b0;
        bus.id_rs2_rd       = 1'b0;
        bus.ex_mem_read     = 1'b0;
        bus.ex_rd           = '0;
        bus.ex_muldiv_start = 1'b0;
        bus.muldiv_done     = 1'b0;
        bus.lsu_wait        = 1'b0;
        bus.lsu_pending     = 1'b0;
        bus.trap_req        = 1'b0;
        bus.mret_req        = 1'b0;
    endtask

    // Move to the next cycle: inputs change just after the falling edge.
    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    task automatic load_use(input logic [REG_AW-1:0] rd);
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = rd;
        bus.id_rs2      = 5'd5;
        bus.id_rs2_rd   = 1'b1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", 32'(w_ctl), 32'(C_NONE));
        check("reset_stall_cnt", stall_cnt, 0);
        check("reset_redir_cnt", redir_cnt, 0);
        rst_n = 1'b1;

        // Load-use on rs2: one bubble
        next_cycle(); load_use(5'd5); #1;
        check("lu_stall", 32'(w_ctl), 32'(C_LU));
        next_cycle(); #1;
        check("lu_release", 32'(w_ctl), 32'(C_NONE));
        check("lu_stall_cnt", stall_cnt, 1);

        // Load into x0: no hazard
        next_cycle(); load_use(5'd0); #1;
        check("lu_x0", 32'(w_ctl), 32'(C_NONE));

        // Matching rs1 that is not read: no hazard
        next_cycle(); bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7;
        bus.id_rs1 = 5'd7; bus.id_rs1_rd = 1'b0; #1;
        check("lu_rs1_unread", 32'(w_ctl), 32'(C_NONE));

        // Branch wins over load-use
        next_cycle(); load_use(5'd5); bus.take_branch = 1'b1; #1;
        check("br_lu", 32'(w_ctl), 32'(C_BR));
        next_cycle(); #1;
        check("br_redir_cnt", redir_cnt, 1);
        check("br_stall_cnt", stall_cnt, 1);

        // MUL/DIV: done 6 cycles after start
        next_cycle(); bus.ex_muldiv_start = 1'b1; #1;
        check("md_start", 32'(w_ctl), 32'(C_MD));
        for (int i = 1; i < 6; i++) begin
            next_cycle(); #1;
            check($sformatf("md_wait%0d", i), 32'(w_ctl), 32'(C_MD));
        end
        next_cycle(); bus.muldiv_done = 1'b1; #1;
        check("md_done", 32'(w_ctl), 32'(C_NONE));
        next_cycle(); #1;
        check("md_run", 32'(w_ctl), 32'(C_NONE));
        check("md_stall_cnt", stall_cnt, 7);

        // Start with same-cycle done: no stall
        next_cycle(); bus.ex_muldiv_start = 1'b1; bus.muldiv_done = 1'b1; #1;
        check("md_same", 32'(w_ctl), 32'(C_NONE));
        next_cycle(); #1;
        check("md_same_next", 32'(w_ctl), 32'(C_NONE));
        check("md_same_cnt", stall_cnt, 7);

        // LSU wait
        next_cycle(); bus.lsu_wait = 1'b1; #1;
        check("lsu_wait", 32'(w_ctl), 32'(C_HOLD));

        // Trap with store pending for 3 cycles
        for (int i = 0; i < 3; i++) begin
            next_cycle(); bus.trap_req = 1'b1; bus.lsu_pending = 1'b1; #1;
            check($sformatf("drain%0d", i), 32'(w_ctl), 32'(C_HOLD));
        end
        next_cycle(); bus.trap_req = 1'b1; #1;
        check("drain_trap", 32'(w_ctl), 32'(C_TRAP));
        next_cycle(); bus.trap_req = 1'b1; #1;
        check("trap_hold", 32'(w_ctl), 32'(C_NONE));
        next_cycle(); #1;
        check("drain_stall_cnt", stall_cnt, 11);
        check("drain_redir_cnt", redir_cnt, 2);

        // mret latched across a drain although the request drops
        next_cycle(); bus.mret_req = 1'b1; bus.lsu_pending = 1'b1; #1;
        check("mret_drain", 32'(w_ctl), 32'(C_HOLD));
        next_cycle(); #1;
        check("mret_latched", 32'(w_ctl), 32'(C_MRET));

        // Trap + mret, no pending: trap wins
        next_cycle(); #1;
        next_cycle(); bus.trap_req = 1'b1; bus.mret_req = 1'b1; #1;
        check("trap_mret", 32'(w_ctl), 32'(C_TRAP));
        next_cycle(); bus.take_branch = 1'b1; #1;
        check("hold_no_branch", 32'(w_ctl), 32'(C_NONE));

        // mret alone
        next_cycle(); bus.mret_req = 1'b1; #1;
        check("mret", 32'(w_ctl), 32'(C_MRET));
        next_cycle(); #1;
        check("mret_redir_cnt", redir_cnt, 5);
        check("mret_stall_cnt", stall_cnt, 12);

        // Async reset in the middle of MD_WAIT
        next_cycle(); bus.ex_muldiv_start = 1'b1; #1;
        next_cycle(); #1;
        check("md_before_rst", 32'(w_ctl), 32'(C_MD));
        rst_n = 1'b0; #1;
        check("rst_mid_ctl", 32'(w_ctl), 32'(C_NONE));
        check("rst_mid_stall_cnt", stall_cnt, 0);
        check("rst_mid_redir_cnt", redir_cnt, 0);
        next_cycle(); rst_n = 1'b1;
        next_cycle(); #1;
        check("after_rst_run", 32'(w_ctl), 32'(C_NONE));
        check("after_rst_cnt", stall_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush/redirect sequencer for the 5-stage veriRISCV core (IF/ID/EX/MEM/WB).
- Supersedes the purely combinational branch flush with a small FSM. The FSM arbitrates between:
  - traps and mret
  - taken branches
  - multi-cycle MUL/DIV waits
  - LSU wait states
  - load-use hazards
- Drives per-stage stall/flush and the PC source select; also keeps stall/redirect performance counters.

Parameters:
- PERF_W, 32, width of stall_cnt and redir_cnt (wrap-around counters).
- REG_AW, 5, register-index width.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- take_branch  input  1  EX branch/jump resolved taken
- id_rs1  input  REG_AW  ID source reg 1
- id_rs2  input  REG_AW  ID source reg 2
- id_rs1_rd  input  1  ID instruction reads rs1
- id_rs2_rd  input  1  ID instruction reads rs2
- ex_mem_read  input  1  EX holds a load
- ex_rd  input  REG_AW  EX destination reg
- ex_muldiv_start  input  1  EX issues multi-cycle MUL/DIV (1-cycle pulse)
- muldiv_done  input  1  MUL/DIV result valid (1-cycle pulse)
- lsu_wait  input  1  MEM access not yet complete
- lsu_pending  input  1  outstanding store/bus transaction
- trap_req  input  1  exception/interrupt raised at MEM
- mret_req  input  1  mret at MEM
- if_stall, id_stall, ex_stall, mem_stall  output  1 each  hold stage register
- if_flush, id_flush, ex_flush, mem_flush, wb_flush  output  1 each  insert bubble into the next register of that stage
- pc_sel  output  2  00 PC+4, 01 branch target, 10 trap vector, 11 mepc
- trap_ack  output  1  1-cycle pulse when trap/mret redirect is taken
- stall_cnt  output  PERF_W  cycles with if_stall=1
- redir_cnt  output  PERF_W  count of pc_sel!=00 cycles

Behaviour:
- Reset (async, rst_n=0): state=RUN; counters=0. All stall/flush/trap_ack=0; pc_sel=00. Outputs are combinational from state and inputs; all outputs are 0 while in reset.
- States: RUN, MD_WAIT, DRAIN, TRAP_HOLD.
- RUN, priority high to low:
  1. (trap_req|mret_req) & !lsu_pending: pc_sel=10 (trap) or 11 (mret; trap wins if both). if/id/ex/mem_flush=1, trap_ack=1, next TRAP_HOLD.
  2. (trap_req|mret_req) & lsu_pending: all four stalls=1, wb_flush=1, next DRAIN. The request kind is latched (trap wins).
  3. take_branch: pc_sel=01, if_flush=id_flush=1. The branch in EX proceeds.
  4. lsu_wait: if/id/ex/mem_stall=1, wb_flush=1; stay RUN.
  5. ex_muldiv_start: if/id/ex_stall=1, mem_flush=1, next MD_WAIT. If muldiv_done is in the same cycle, no stall and stay RUN.
  6. Load-use: ex_mem_read & ex_rd!=0 & ((id_rs1_rd & id_rs1==ex_rd) | (id_rs2_rd & id_rs2==ex_rd)). Response: if_stall=id_stall=1, ex_flush=1; exactly one bubble.
- MD_WAIT:
  - Holds if/id/ex_stall=1 and mem_flush=1 until muldiv_done.
  - On done: no stall that cycle, next RUN.
  - trap_req during MD_WAIT is ignored; MEM is bubbled, so none can legally arrive.
- DRAIN:
  - All stalls=1, wb_flush=1 while lsu_pending.
  - When lsu_pending=0: perform the latched redirect exactly as RUN case 1, next TRAP_HOLD.
- TRAP_HOLD:
  - One cycle; trap_req/mret_req are ignored (prevents a double trap from the same MEM instruction).
  - take_branch is ignored (EX was flushed). Next RUN.
- take_branch and load-use in the same cycle: the branch wins. No stall; ID is flushed.
- Counters: +1 per qualifying cycle, wrapping modulo 2^PERF_W. Counting is unaffected by state.
- Reset mid-MD_WAIT or mid-DRAIN returns to RUN immediately; the latched request is discarded.

Decomposition:
- Shared package/header (core.vh): PC_SEL_* constants (00/01/10/11) and state encodings PC_RUN, PC_MD_WAIT, PC_DRAIN, PC_TRAP_HOLD.
- One sub-module, lu_hazard_det: combinational load-use compare returning a 1-bit hazard. Reused by forwarding checks.
- FSM and counters stay in pipe_ctrl.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_rd=1 -> one cycle of if_stall=id_stall=ex_flush=1, then all 0; stall_cnt=1. Same with ex_rd=0 -> no stall.
- Branch with simultaneous hazard: take_branch=1 plus load-use match -> pc_sel=01, if_flush=id_flush=1, no stalls; redir_cnt=1.
- MUL/DIV: start pulse, done 6 cycles later -> if/id/ex_stall=1 and mem_flush=1 for 6 cycles, then RUN. Start with same-cycle done -> 0 stall cycles.
- Trap with pending store: trap_req=1, lsu_pending high for 3 cycles -> 3 cycles of all stalls plus wb_flush. Then pc_sel=10, four flushes, trap_ack for 1 cycle. trap_req held high next cycle -> ignored (TRAP_HOLD).
- Simultaneous trap_req+mret_req with no pending -> pc_sel=10. mret_req alone -> pc_sel=11, trap_ack=1.
- Async reset asserted mid-MD_WAIT -> all outputs 0 immediately. After release: state RUN, counters 0.
